enemies_controller: RTL and testbench
=====================================

Name: enemies_controller

Overview:
- Owns the packed per-slot enemy state vector (8 slots × 19 bits) that drives the enemy rendering path.
- Once per frame, on a frame tick issued during vertical blanking, it sequences one slot per cycle, performing:
  - hit resolution against the per-angle hit mask;
  - inward movement;
  - reach detection;
  - a single pseudo-random spawn.
- The state vector is stable for the whole visible frame.

Parameters:
- SPAWN_INTERVAL, 60: frames between spawn attempts (1..255).
- SPAWN_DISTANCE, 200: distance loaded into a newly spawned enemy (8-bit).
- MOVE_DIV, 2: frames per movement step (1..15); enemies move only on every MOVE_DIV-th update pass.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  game running; when low, frame_tick is ignored
- clear  in  1  synchronous clear of all slots (game over / restart)
- frame_tick  in  1  one-cycle pulse per frame, issued at vblank start
- angles_hit  in  16  bit k set = player fired at angle k this frame
- state  out  152  slot i at [19*(i+1)-1:19*i], packed {alive, angle[3:0], kind[1:0], distance[7:0], health[3:0]}
- busy  out  1  update pass in progress
- update_done  out  1  one-cycle pulse after the pass completes
- kill_pulse  out  1  one cycle per enemy killed by a hit
- reach_pulse  out  1  one cycle per enemy reaching the centre

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values (rst_n low at an edge):
  - state, busy, update_done, kill_pulse, reach_pulse all 0;
  - FSM = IDLE;
  - spawn timer = SPAWN_INTERVAL;
  - move counter = 0;
  - LFSR = LFSR_SEED.
  - Reset mid-pass aborts the pass; no partial update survives.
- clear (rst_n high): same as reset, except the LFSR is not reseeded. clear outranks frame_tick in the same cycle.
- LFSR:
  - 16-bit Galois, taps 16,14,13,11.
  - Advances every cycle when rst_n is high, including during clear.
- FSM: IDLE → UPDATE → SPAWN → IDLE.
  - IDLE: frame_tick && enable at cycle T does three things:
    - latch angles_hit into hit_q;
    - set move_now = (move counter == MOVE_DIV-1); the move counter then wraps to 0, otherwise increments;
    - go to UPDATE with slot index 0.
  - frame_tick while busy, or while enable is low, is ignored.
  - UPDATE: slot i is processed in cycle T+1+i, index 0..7, with its register written at the end of that cycle. Per slot, in this order:
    - not alive: unchanged.
    - alive and hit_q[angle]:
      - health ≤ 1: alive ← 0, health ← 0, kill_pulse that cycle, no movement.
      - otherwise: health ← health − 1.
    - alive survivor with move_now: step = speed(kind).
      - distance ≤ step: alive ← 0, distance ← 0, reach_pulse that cycle.
      - otherwise: distance ← distance − step.
    - A hit and a move in the same pass are both applied.
    - kill_pulse and reach_pulse are mutually exclusive per cycle.
  - SPAWN (cycle T+9):
    - Spawn timer decrements once per pass.
    - At 0 it reloads SPAWN_INTERVAL and, if any slot is dead, the lowest-index dead slot is loaded with:
      - alive = 1;
      - angle = lfsr[3:0];
      - kind = lfsr[5:4];
      - distance = SPAWN_DISTANCE;
      - health = health(kind).
    - A slot freed earlier in the same pass is eligible.
    - All slots full: the spawn is dropped and the timer still reloads.
  - Outputs after the pass:
    - busy is high in cycles T+1..T+9.
    - update_done is high in cycle T+10.
    - state is final from cycle T+10.
- Kind table, health/speed: kind 0 = 1/1, kind 1 = 2/2, kind 2 = 4/1, kind 3 = 8/3.
- Width rules:
  - distance and health arithmetic is unsigned and never wraps below 0.
  - An alive slot never has health 0.
- Killed or reached slots retain their angle and kind fields (don't-care for the renderer).

Decomposition:
- Shared package/include enemies_pkg holds:
  - ENEMY_STATE_WIDTH = 19 and NUM_ENEMIES = 8;
  - field bit offsets for alive, angle, kind, distance and health;
  - the kind health and speed tables.
  - The renderer-side decoder imports the same definitions.
- Sub-module: enemy_lfsr, the 16-bit Galois LFSR with seed parameter.

Test Plan:
- Reset: rst_n low for 2 cycles, then 100 frame_ticks with SPAWN_INTERVAL=1 and no hits → exactly one spawn per pass until all 8 slots are alive. The first spawn goes to slot 0 with distance 200 and health matching the kind table.
- Movement, MOVE_DIV=1:
  - kind 1 at distance 5: pass 1 → 3, pass 2 → 1, pass 3 → alive 0 with reach_pulse in the slot-i cycle.
  - kind 0 at distance 1 → reached on the first pass.
- Hits: kind 2 (health 4) at angle 7 with angles_hit=16'h0080 on 4 passes → health 3,2,1, then killed on pass 4. Exactly one kill_pulse, in cycle T+1+slot, and no movement on the kill pass.
- Timing: frame_tick at T → busy over T+1..T+9 and update_done at T+10. A second frame_tick at T+4 is ignored (one pass only). enable=0 frame_tick → no change.
- Full and clear:
  - all 8 alive with spawn due → no spawn, timer reloads to SPAWN_INTERVAL.
  - clear asserted mid-pass (T+5) → state all zero next cycle, FSM IDLE, LFSR keeps running.
- Concurrent events: slot 3 killed and slot 5 reached in one pass → pulses at T+4 and T+6, and the spawn in that pass lands in slot 3.

Source files
------------

// File: rtl/enemies_pkg.sv
// enemies_pkg: definitions shared by the enemy controller and the
// renderer-side decoder. It covers the per-slot state layout, the field bit
// offsets, the kind health/speed tables and the controller FSM encoding.
package enemies_pkg;

    localparam int ENEMY_STATE_WIDTH = 19;
    localparam int NUM_ENEMIES       = 8;
    localparam int STATE_WIDTH       = ENEMY_STATE_WIDTH * NUM_ENEMIES;

    // Bit offsets inside one 19-bit slot.
    localparam int HEALTH_LSB   = 0;
    localparam int DISTANCE_LSB = 4;
    localparam int KIND_LSB     = 12;
    localparam int ANGLE_LSB    = 14;
    localparam int ALIVE_BIT    = 18;

    // Field order matches the offsets above, MSB first.
    typedef struct packed {
        logic       alive;
        logic [3:0] angle;
        logic [1:0] kind;
        logic [7:0] distance;
        logic [3:0] health;
    } enemy_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UPDATE,
        ST_SPAWN
    } ctrl_state_t;

    function automatic logic [3:0] kind_health(input logic [1:0] kind);
        case (kind)
            2'd0:    kind_health = 4'd1;
            2'd1:    kind_health = 4'd2;
            2'd2:    kind_health = 4'd4;
            default: kind_health = 4'd8;
        endcase
    endfunction

    function automatic logic [7:0] kind_speed(input logic [1:0] kind);
        case (kind)
            2'd0:    kind_speed = 8'd1;
            2'd1:    kind_speed = 8'd2;
            2'd2:    kind_speed = 8'd1;
            default: kind_speed = 8'd3;
        endcase
    endfunction

endpackage

// File: rtl/enemies_controller_if.sv
// enemies_controller_if: control and status bundle of the enemy controller.
//   enable, clear, frame_tick, angles_hit : game-side controls into the block
//   state                                 : packed 8 x 19-bit slot vector
//   busy, update_done                     : update pass status
//   kill_pulse, reach_pulse               : per-enemy event strobes
// master = game/test side, slave = controller.
interface enemies_controller_if;
    import enemies_pkg::*;

    logic                   enable;
    logic                   clear;
    logic                   frame_tick;
    logic [15:0]            angles_hit;
    logic [STATE_WIDTH-1:0] state;
    logic                   busy;
    logic                   update_done;
    logic                   kill_pulse;
    logic                   reach_pulse;

    modport master (
        output enable, clear, frame_tick, angles_hit,
        input  state, busy, update_done, kill_pulse, reach_pulse
    );

    modport slave (
        input  enable, clear, frame_tick, angles_hit,
        output state, busy, update_done, kill_pulse, reach_pulse
    );

endinterface

// File: rtl/enemy_lfsr.sv
// enemy_lfsr: 16-bit Galois LFSR (taps 16,14,13,11) that free-runs every
// cycle out of reset. Only the low six bits are exported because they are
// all the spawner consumes (angle and kind).
//   clk, rst_n : clock, synchronous active-low reset (loads SEED)
//   rnd        : lfsr[5:0]
module enemy_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [5:0] rnd
);
    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;

    // Right-shifting Galois form: the bit shifted out folds back into the taps.
    always_comb begin
        lfsr_next = {1'b0, lfsr_reg[15:1]};
        if (lfsr_reg[0]) begin
            lfsr_next = lfsr_next ^ 16'hB400;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_reg <= SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign rnd = lfsr_reg[5:0];

endmodule

// File: rtl/enemies_controller.sv
// enemies_controller: owns the 8-slot enemy state vector. On an enabled
// frame_tick it walks the slots one per cycle. For each slot it resolves hits,
// then moves the enemy inward and detects when it reaches the centre. After
// the walk it runs one spawn cycle. The state vector only changes during the
// pass.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : enemies_controller_if.slave (controls, state, status, pulses)
module enemies_controller
    import enemies_pkg::*;
#(
    parameter int          SPAWN_INTERVAL = 60,
    parameter int          SPAWN_DISTANCE = 200,
    parameter int          MOVE_DIV       = 2,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    enemies_controller_if.slave  bus
);
    enemy_t      slots_reg [NUM_ENEMIES];
    ctrl_state_t fsm_reg, fsm_next;
    logic [2:0]  slot_idx_reg;
    logic [15:0] hit_reg;
    logic        move_now_reg;
    logic [3:0]  move_cnt_reg;
    logic [7:0]  spawn_timer_reg;
    logic        update_done_reg;

    logic [5:0]  rnd;
    enemy_t      cur, upd, spawn_enemy;
    logic        kill, reach;
    logic [7:0]  step;
    logic        free_found;
    logic [2:0]  free_idx;
    logic        start;
    logic        spawn_due;

    enemy_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .rnd   (rnd)
    );

    assign start     = bus.frame_tick && bus.enable;
    assign cur       = slots_reg[slot_idx_reg];
    // The timer counts down to zero across passes. A value of 1 here means
    // this pass decrements it to zero, so this pass spawns.
    assign spawn_due = (spawn_timer_reg <= 8'd1);

    // Per-slot resolution. A killed enemy does not move. A surviving hit
    // enemy still moves in the same pass.
    always_comb begin
        upd   = cur;
        kill  = 1'b0;
        reach = 1'b0;
        step  = kind_speed(cur.kind);
        if (cur.alive) begin
            if (hit_reg[cur.angle]) begin
                if (cur.health <= 4'd1) begin
                    upd.alive  = 1'b0;
                    upd.health = 4'd0;
                    kill       = 1'b1;
                end else begin
                    upd.health = cur.health - 4'd1;
                end
            end
            if (!kill && move_now_reg) begin
                if (cur.distance <= step) begin
                    upd.alive    = 1'b0;
                    upd.distance = 8'd0;
                    reach        = 1'b1;
                end else begin
                    upd.distance = cur.distance - step;
                end
            end
        end
    end

    // Lowest-index dead slot. The loop runs from high to low so the last hit
    // wins. Slots freed earlier in this pass are already written back by the
    // time the SPAWN cycle reads them.
    always_comb begin
        free_found = 1'b0;
        free_idx   = 3'd0;
        for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
            if (!slots_reg[i].alive) begin
                free_found = 1'b1;
                free_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        spawn_enemy.alive    = 1'b1;
        spawn_enemy.angle    = rnd[3:0];
        spawn_enemy.kind     = rnd[5:4];
        spawn_enemy.distance = 8'(SPAWN_DISTANCE);
        spawn_enemy.health   = kind_health(rnd[5:4]);
    end

    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            ST_IDLE:   if (start) fsm_next = ST_UPDATE;
            ST_UPDATE: if (slot_idx_reg == 3'(NUM_ENEMIES - 1)) fsm_next = ST_SPAWN;
            ST_SPAWN:  fsm_next = ST_IDLE;
            default:   fsm_next = ST_IDLE;
        endcase
    end

    // clear behaves like reset for everything here. The LFSR lives in the
    // sub-module and only sees rst_n, so it keeps running through a clear.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear) begin
            fsm_reg         <= ST_IDLE;
            slot_idx_reg    <= 3'd0;
            hit_reg         <= 16'd0;
            move_now_reg    <= 1'b0;
            move_cnt_reg    <= 4'd0;
            spawn_timer_reg <= 8'(SPAWN_INTERVAL);
            update_done_reg <= 1'b0;
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                slots_reg[i] <= '0;
            end
        end else begin
            fsm_reg         <= fsm_next;
            update_done_reg <= (fsm_reg == ST_SPAWN);
            case (fsm_reg)
                ST_IDLE: begin
                    if (start) begin
                        hit_reg      <= bus.angles_hit;
                        slot_idx_reg <= 3'd0;
                        if (move_cnt_reg == 4'(MOVE_DIV - 1)) begin
                            move_now_reg <= 1'b1;
                            move_cnt_reg <= 4'd0;
                        end else begin
                            move_now_reg <= 1'b0;
                            move_cnt_reg <= move_cnt_reg + 4'd1;
                        end
                    end
                end
                ST_UPDATE: begin
                    slots_reg[slot_idx_reg] <= upd;
                    slot_idx_reg            <= slot_idx_reg + 3'd1;
                end
                ST_SPAWN: begin
                    if (spawn_due) begin
                        spawn_timer_reg <= 8'(SPAWN_INTERVAL);
                        if (free_found) begin
                            slots_reg[free_idx] <= spawn_enemy;
                        end
                    end else begin
                        spawn_timer_reg <= spawn_timer_reg - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (fsm_reg != ST_IDLE);
    assign bus.update_done = update_done_reg;
    assign bus.kill_pulse  = (fsm_reg == ST_UPDATE) && kill;
    assign bus.reach_pulse = (fsm_reg == ST_UPDATE) && reach;

    generate
        for (genvar gi = 0; gi < NUM_ENEMIES; gi++) begin : g_pack
            assign bus.state[gi*ENEMY_STATE_WIDTH +: ENEMY_STATE_WIDTH] = slots_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_enemies_controller.sv
// tb_enemies_controller: randomized scoreboard bench. Each accepted frame
// tick runs the behavioural slot model for one whole pass. That pushes the
// expected kill/reach pulses and the final state, each tagged with the cycle
// it is due in. A separate negedge monitor pops and compares whenever the DUT
// strobes an event, and it checks busy every cycle.
module tb_enemies_controller;
    import enemies_pkg::*;

    localparam int          SI   = 3;
    localparam int          SD   = 40;
    localparam int          MD   = 2;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int EV_KILL = 0, EV_REACH = 1, EV_DONE = 2;

    typedef struct {
        int           kind;
        int           cyc;
        logic [151:0] st;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    enemies_controller_if bus();

    enemies_controller #(
        .SPAWN_INTERVAL (SI),
        .SPAWN_DISTANCE (SD),
        .MOVE_DIV       (MD),
        .LFSR_SEED      (SEED)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR: shift right; if a 1 drops out, xor in the tap mask.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge clk) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    // Behavioural slot model.
    bit         m_alive [8];
    logic [3:0] m_angle [8];
    logic [1:0] m_kind  [8];
    int         m_dist  [8];
    int         m_hp    [8];
    int         m_timer, m_move_cnt;
    int HP_TAB  [4] = '{1, 2, 4, 8};
    int SPD_TAB [4] = '{1, 2, 1, 3};

    ev_t exp_q[$];
    int  n_cmp = 0, n_bad = 0;
    int  busy_lo = -1, busy_hi = -2, skip_cyc = -1;
    bit  mon_en = 1'b0;

    function automatic string ev_name(input int k);
        case (k)
            EV_KILL:  return "kill";
            EV_REACH: return "reach";
            default:  return "done";
        endcase
    endfunction

    function automatic logic [151:0] model_pack();
        logic [151:0] s;
        s = '0;
        for (int i = 0; i < 8; i++)
            s[19*i +: 19] = {m_alive[i], m_angle[i], m_kind[i], 8'(m_dist[i]), 4'(m_hp[i])};
        return s;
    endfunction

    task automatic push_ev(input int k, input int c, input logic [151:0] s);
        ev_t e;
        e.kind = k; e.cyc = c; e.st = s;
        exp_q.push_back(e);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_alive[i] = 1'b0; m_angle[i] = 4'd0; m_kind[i] = 2'd0;
            m_dist[i] = 0; m_hp[i] = 0;
        end
        m_timer = SI;
        m_move_cnt = 0;
    endtask

    task automatic model_pass(input int t0, input logic [15:0] hits);
        bit          move_now;
        logic [15:0] lf;
        int          free;
        move_now   = (m_move_cnt == MD - 1);
        m_move_cnt = move_now ? 0 : m_move_cnt + 1;
        for (int i = 0; i < 8; i++) begin
            bit killed;
            killed = 1'b0;
            if (m_alive[i]) begin
                if (hits[m_angle[i]]) begin
                    if (m_hp[i] <= 1) begin
                        m_alive[i] = 1'b0; m_hp[i] = 0; killed = 1'b1;
                        push_ev(EV_KILL, t0 + 1 + i, '0);
                    end else begin
                        m_hp[i]--;
                    end
                end
                if (!killed && move_now) begin
                    if (m_dist[i] <= SPD_TAB[m_kind[i]]) begin
                        m_alive[i] = 1'b0; m_dist[i] = 0;
                        push_ev(EV_REACH, t0 + 1 + i, '0);
                    end else begin
                        m_dist[i] -= SPD_TAB[m_kind[i]];
                    end
                end
            end
        end
        // The spawn happens in cycle t0+9, nine LFSR steps after cycle t0.
        lf = m_lfsr;
        repeat (9) lf = lfsr_step(lf);
        m_timer--;
        if (m_timer == 0) begin
            m_timer = SI;
            free = -1;
            for (int i = 7; i >= 0; i--) if (!m_alive[i]) free = i;
            if (free >= 0) begin
                m_alive[free] = 1'b1;
                m_angle[free] = lf[3:0];
                m_kind[free]  = lf[5:4];
                m_dist[free]  = SD;
                m_hp[free]    = HP_TAB[lf[5:4]];
            end
        end
        push_ev(EV_DONE, t0 + 10, model_pack());
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [151:0] act, input logic [151:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic take_ev(input int k);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_%s cycle %0d: DUT strobed it, scoreboard empty", ev_name(k), cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != k || e.cyc != cyc) begin
            n_bad++;
            $display("FAIL event_order: got %s at cycle %0d, expected %s at cycle %0d",
                     ev_name(k), cyc, ev_name(e.kind), e.cyc);
        end else if (k == EV_DONE) begin
            check_vec("state_after_pass", bus.state, e.st);
            $display("pass done cycle %0d state %h", cyc, bus.state);
        end else begin
            $display("%s pulse cycle %0d", ev_name(k), cyc);
        end
    endtask

    // Monitor: decoupled from stimulus, driven only by what the DUT shows.
    always @(negedge clk) begin
        if (mon_en) begin
            check_bit("busy", bus.busy, (cyc >= busy_lo && cyc <= busy_hi));
            if (cyc != skip_cyc) begin
                if (bus.kill_pulse)  take_ev(EV_KILL);
                if (bus.reach_pulse) take_ev(EV_REACH);
                if (bus.update_done) take_ev(EV_DONE);
            end
        end
    end

    // Drop the events an abort cancels. Anything due before the abort cycle
    // should already have been consumed.
    task automatic flush(input int c);
        int stale;
        ev_t e;
        stale = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.cyc < c) stale++;
        end
        n_cmp++;
        if (stale != 0) begin
            n_bad++;
            $display("FAIL missed_events cycle %0d: got %0d still pending expected 0", c, stale);
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_abort(input bit use_rst);
        int c;
        c = cyc;
        if (use_rst) rst_n = 1'b0;
        else begin
            bus.clear = 1'b1;
            bus.frame_tick = 1'b1;   // clear must win over a same-cycle tick
        end
        $display("abort (%s) cycle %0d", use_rst ? "reset" : "clear", c);
        skip_cyc = c;
        if (busy_hi >= c) busy_hi = c;
        flush(c);
        model_clear();
        step_cycle();
        rst_n = 1'b1;
        bus.clear = 1'b0;
        bus.frame_tick = 1'b0;
        @(negedge clk);
        check_vec("state_after_abort", bus.state, '0);
        step_cycle();
    endtask

    task automatic run_pass(input logic [15:0] hits, input int extra_at,
                            input int abort_at, input bit abort_rst);
        int t0;
        t0 = cyc;
        bus.frame_tick = 1'b1;
        bus.enable     = 1'b1;
        bus.angles_hit = hits;
        model_pass(t0, hits);
        busy_lo = t0 + 1;
        busy_hi = t0 + 9;
        for (int k = 1; k <= 10; k++) begin
            step_cycle();
            bus.frame_tick = (k == extra_at);
            bus.angles_hit = 16'($urandom);
            if (k == abort_at) begin
                do_abort(abort_rst);
                return;
            end
        end
    endtask

    task automatic enable_low_tick();
        bus.enable = 1'b0;
        bus.frame_tick = 1'b1;
        step_cycle();
        bus.frame_tick = 1'b0;
        bus.enable = 1'b1;
        repeat (12) step_cycle();
        check_vec("state_enable_low", bus.state, model_pack());
    endtask

    initial begin
        bus.enable = 1'b1; bus.clear = 1'b0; bus.frame_tick = 1'b0; bus.angles_hit = 16'h0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_vec("reset_state", bus.state, '0);
        check_bit("reset_busy", bus.busy, 1'b0);
        check_bit("reset_update_done", bus.update_done, 1'b0);
        check_bit("reset_kill", bus.kill_pulse, 1'b0);
        check_bit("reset_reach", bus.reach_pulse, 1'b0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        step_cycle();

        // Fill, saturate (dropped spawns) and let enemies reach the centre.
        for (int p = 0; p < 70; p++)
            run_pass(16'h0, ($urandom % 3 == 0) ? int'($urandom_range(1, 9)) : 0, 0, 1'b0);
        enable_low_tick();

        // Random hits with occasional clear/reset aborts mid-pass.
        for (int p = 0; p < 150; p++) begin
            int ab;
            ab = ($urandom % 15 == 0) ? int'($urandom_range(1, 9)) : 0;
            run_pass(16'($urandom & $urandom),
                     ($urandom % 3 == 0) ? int'($urandom_range(1, 9)) : 0,
                     ab, ($urandom % 3 == 0));
            repeat ($urandom % 3) step_cycle();
        end

        do_abort(1'b0);   // clear + tick while idle: no pass may start
        enable_low_tick();
        for (int p = 0; p < 30; p++) begin
            run_pass(16'($urandom & $urandom & $urandom), 0, 0, 1'b0);
            repeat ($urandom % 3) step_cycle();
        end

        repeat (12) step_cycle();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
